// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU memory-port definitions: FSM encodings, requester port indices, default timeout.
package mem_port_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_MEM = 1'b1;

   localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;

endpackage

// File: rtl/MUX2T1X32.sv
// 32-bit 2-to-1 selector, purely combinational; S = 1 selects I1.
module MUX2T1X32 (
   input  logic [31:0] I0,
   input  logic [31:0] I1,
   input  logic        S,
   output logic [31:0] O
);

   assign O = S ? I1 : I0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of the memory port between fetch (port 0) and data (port 1); grant one cycle after REQ,
// held until MEM_READY (or timeout abort when ARB_TIMEOUT_EN is defined). Requesters stall by holding REQ.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [31:0] ADDR0,
   input  logic [31:0] ADDR1,
   input  logic [31:0] WDATA0,
   input  logic [31:0] WDATA1,
   input  logic        WE0,
   input  logic        WE1,
   output logic        ACK0,
   output logic        ACK1,
   output logic [31:0] RDATA,
   output logic        ERR,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic        MEM_WE,
   input  logic        MEM_READY,
   input  logic [31:0] MEM_RDATA
);

   state_t state;
   logic   gnt;
   logic   last;
   logic   busy;
   logic   pick;
   logic   abort;
   logic   done;
   logic   ok_done;

   assign busy = (state == ST_BUSY);

   // On a tie the port not served last wins; otherwise the lone requester.
   assign pick = (REQ0 && REQ1) ? ~last : REQ1;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt;

   // MEM_READY in the expiry cycle completes normally.
   assign abort = busy && !MEM_READY && (cnt == TIMEOUT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= 8'd0;
      end else if (!busy) begin
         cnt <= 8'd0;
      end else if (!MEM_READY && (cnt != TIMEOUT)) begin
         cnt <= cnt + 8'd1;
      end
   end
`else
   logic unused_timeout;

   assign abort          = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   assign ok_done = busy && MEM_READY && !RST;
   assign done    = busy && (MEM_READY || abort) && !RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         gnt   <= PORT_IF;
         last  <= PORT_MEM;
      end else begin
         case (state)
            ST_IDLE: begin
               if (REQ0 || REQ1) begin
                  gnt   <= pick;
                  last  <= pick;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (done) begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign MEM_REQ = busy;
   assign MEM_WE  = gnt ? WE1 : WE0;

   MUX2T1X32 u_addr_mux (
      .I0 (ADDR0),
      .I1 (ADDR1),
      .S  (gnt),
      .O  (MEM_ADDR)
   );

   MUX2T1X32 u_wdata_mux (
      .I0 (WDATA0),
      .I1 (WDATA1),
      .S  (gnt),
      .O  (MEM_WDATA)
   );

   assign ACK0  = done && (gnt == PORT_IF);
   assign ACK1  = done && (gnt == PORT_MEM);
   assign ERR   = done && abort;
   assign RDATA = ok_done ? MEM_RDATA : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; timeout cases build only with ARB_TIMEOUT_EN (TIMEOUT = 4).
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ0, REQ1;
   logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
   logic        WE0, WE1;
   logic        ACK0, ACK1, ERR;
   logic [31:0] RDATA;
   logic        MEM_REQ, MEM_WE;
   logic [31:0] MEM_ADDR, MEM_WDATA;
   logic        MEM_READY;
   logic [31:0] MEM_RDATA;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.TIMEOUT(8'd4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ0      (REQ0),
      .REQ1      (REQ1),
      .ADDR0     (ADDR0),
      .ADDR1     (ADDR1),
      .WDATA0    (WDATA0),
      .WDATA1    (WDATA1),
      .WE0       (WE0),
      .WE1       (WE1),
      .ACK0      (ACK0),
      .ACK1      (ACK1),
      .RDATA     (RDATA),
      .ERR       (ERR),
      .MEM_REQ   (MEM_REQ),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_WE    (MEM_WE),
      .MEM_READY (MEM_READY),
      .MEM_RDATA (MEM_RDATA)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Advance to just after the next rising edge; inputs are then driven, outputs checked after a settle.
   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; MEM_READY = 0;
      ADDR0 = 32'h0; ADDR1 = 32'h0; WDATA0 = 32'h0; WDATA1 = 32'h0; MEM_RDATA = 32'h0;
   endtask

   task automatic do_reset();
      RST = 1;
      clear_inputs();
      cyc();
      cyc();
      RST = 0;
   endtask

   initial begin
      logic       exp_busy;
      logic [1:0] k;

      do_reset();
      settle();
      check("rst_mem_req", MEM_REQ, 0);
      check("rst_ack0",    ACK0, 0);
      check("rst_ack1",    ACK1, 0);
      check("rst_err",     ERR, 0);
      check("rst_rdata",   RDATA, 0);

      // Single read, memory ready in first BUSY cycle.
      cyc();
      REQ0 = 1; ADDR0 = 32'h0000_0040; MEM_READY = 1; MEM_RDATA = 32'hDEAD_BEEF;
      settle();
      check("rd_idle_mem_req", MEM_REQ, 0);
      check("rd_idle_ack0",    ACK0, 0);
      check("rd_idle_rdata",   RDATA, 0);
      cyc();
      settle();
      check("rd_mem_req", MEM_REQ, 1);
      check("rd_addr",    MEM_ADDR, 32'h40);
      check("rd_we",      MEM_WE, 0);
      check("rd_ack0",    ACK0, 1);
      check("rd_ack1",    ACK1, 0);
      check("rd_rdata",   RDATA, 32'hDEADBEEF);
      cyc();
      REQ0 = 0; MEM_READY = 0;
      settle();
      check("rd_after_mem_req", MEM_REQ, 0);
      check("rd_after_ack0",    ACK0, 0);

      // Tie from reset: port 0 first, then strict alternation with an IDLE cycle between grants.
      do_reset();
      REQ0 = 1; REQ1 = 1; ADDR0 = 32'hA000_0000; ADDR1 = 32'hB000_0000;
      MEM_READY = 1; MEM_RDATA = 32'h5555_AAAA;
      for (int i = 0; i < 8; i++) begin
         settle();
         exp_busy = (i % 2) == 1;
         k = 2'((i / 2) % 2);
         check("tie_mem_req", MEM_REQ, exp_busy);
         check("tie_ack0", ACK0, exp_busy && (k == 0));
         check("tie_ack1", ACK1, exp_busy && (k == 1));
         if (exp_busy)
            check("tie_addr", MEM_ADDR, (k == 0) ? 32'hA000_0000 : 32'hB000_0000);
         cyc();
      end
      REQ0 = 0; REQ1 = 0; MEM_READY = 0;
      settle();
      check("tie_end_mem_req", MEM_REQ, 0);

      // Write on port 1, memory stalls three cycles before completing.
      cyc();
      REQ1 = 1; WE1 = 1; WDATA1 = 32'h1234_5678; ADDR1 = 32'h0000_0100;
      WE0 = 0; WDATA0 = 32'hFFFF_FFFF;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         MEM_READY = (i == 4);
         settle();
         check("wr_mem_req", MEM_REQ, 1);
         check("wr_we",      MEM_WE, 1);
         check("wr_wdata",   MEM_WDATA, 32'h12345678);
         check("wr_addr",    MEM_ADDR, 32'h100);
         check("wr_ack1",    ACK1, (i == 4));
         check("wr_ack0",    ACK0, 0);
         check("wr_err",     ERR, 0);
      end
      cyc();
      REQ1 = 0; WE1 = 0; MEM_READY = 0;
      settle();
      check("wr_after_mem_req", MEM_REQ, 0);
      check("wr_after_ack1",    ACK1, 0);

      // Reset during the second BUSY cycle, memory answers one cycle later.
      cyc();
      REQ0 = 1; ADDR0 = 32'h0000_0200;
      cyc();
      settle();
      check("rst_mid_busy1", MEM_REQ, 1);
      cyc();
      RST = 1;
      settle();
      check("rst_mid_ack0", ACK0, 0);
      check("rst_mid_err",  ERR, 0);
      cyc();
      RST = 0; REQ0 = 0; MEM_READY = 1; MEM_RDATA = 32'hCAFE_F00D;
      settle();
      check("rst_mid_mem_req", MEM_REQ, 0);
      check("rst_mid_late_ack0", ACK0, 0);
      check("rst_mid_late_err",  ERR, 0);
      check("rst_mid_rdata",     RDATA, 0);
      cyc();
      MEM_READY = 0;
      settle();
      check("rst_mid_mem_req2", MEM_REQ, 0);
      check("rst_mid_ack0_2",   ACK0, 0);

`ifdef ARB_TIMEOUT_EN
      // Timeout: TIMEOUT = 4 aborts on the fifth BUSY cycle.
      cyc();
      REQ0 = 1; MEM_READY = 0; MEM_RDATA = 32'h1111_2222;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         settle();
         check("to_mem_req", MEM_REQ, 1);
         check("to_ack0",    ACK0, (i == 5));
         check("to_err",     ERR, (i == 5));
         check("to_rdata",   RDATA, 0);
      end
      cyc();
      REQ0 = 0;
      settle();
      check("to_after_mem_req", MEM_REQ, 0);

      // MEM_READY in the expiry cycle wins over the abort.
      cyc();
      REQ0 = 1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         MEM_READY = (i == 5);
         settle();
         check("tot_ack0", ACK0, (i == 5));
         check("tot_err",  ERR, 0);
         if (i == 5)
            check("tot_rdata", RDATA, 32'h11112222);
      end
      cyc();
      REQ0 = 0; MEM_READY = 0;
      settle();
      check("tot_after_mem_req", MEM_REQ, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester round-robin arbiter that shares the CPU's single 32-bit memory port between instruction fetch (port 0) and data access (port 1). It holds one grant per transaction from request to memory completion. Address, write data and write enable are steered onto the memory port through a 32-bit 2-to-1 selection. The block sits between the fetch/MEM stages and the memory interface.

## Interface
- TIMEOUT, 255: BUSY cycles without MEM_READY before abort. Width 8 bits, legal range 1..255. Only used when ARB_TIMEOUT_EN is defined.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- REQ0, REQ1  in  1  transaction request, port 0 / port 1
- ADDR0, ADDR1  in  32  request address
- WDATA0, WDATA1  in  32  write data
- WE0, WE1  in  1  1 = write, 0 = read
- ACK0, ACK1  out  1  transaction-complete strobe for that port
- RDATA  out  32  read data, valid when ACK0 or ACK1 is high
- ERR  out  1  timeout abort strobe, asserted together with ACKn
- MEM_REQ  out  1  memory access active
- MEM_ADDR, MEM_WDATA  out  32  steered address and write data
- MEM_WE  out  1  steered write enable
- MEM_READY  in  1  memory completes the access this cycle
- MEM_RDATA  in  32  memory read data, valid with MEM_READY

## Operation
- FSM states: IDLE and BUSY. Registers: STATE, GNT (granting port), LAST (port last granted), CNT (timeout counter).
- IDLE, no REQ: remain in IDLE.
- IDLE, exactly one REQn: GNT <= n, go to BUSY.
- IDLE, both REQ: GNT <= the port that is not LAST, go to BUSY.
- Every grant also updates LAST <= granted port.
- BUSY:
  - MEM_REQ = 1.
  - MEM_ADDR, MEM_WDATA, MEM_WE = inputs of the GNT port, selected by GNT.
  - MEM_READY = 1: ACK(GNT) = 1 combinationally, RDATA = MEM_RDATA, next state IDLE.
- MEM_REQ is 0 in IDLE.
- MEM_ADDR, MEM_WDATA, MEM_WE always follow the GNT port, so they are don't-care to memory while MEM_REQ = 0.
- ACK and ERR are 0 outside BUSY.
- RDATA is 0 whenever no ACK is asserted.
- Requester rules:
  - Hold REQ, ADDR, WDATA and WE stable from request until the ACK cycle inclusive.
  - REQ sampled in the cycle after ACK counts as a new request.
  - Deasserting REQ before ACK is illegal; behaviour is undefined.
- Write transactions complete the same way as reads. RDATA passes MEM_RDATA unchanged and is ignored by the requester.

## Timing
- Reset values:
  - STATE = IDLE, GNT = 0, LAST = 1 (port 0 wins the first tie), CNT = 0.
  - All outputs 0.
- REQn high in IDLE cycle t: MEM_REQ high in cycle t+1. The earliest ACK is also cycle t+1, when MEM_READY is already high.
- Minimum occupancy: 2 cycles per transaction. The port returns to IDLE for exactly one cycle between transactions.
- Continuous requests from both ports strictly alternate grants 0, 1, 0, 1, …
- RST high mid-transaction:
  - IDLE and MEM_REQ = 0 from the next cycle.
  - A MEM_READY arriving later is ignored and no ACK is produced.
  - Reset has priority over MEM_READY in the same cycle.
- Simultaneous MEM_READY and timeout expiry: MEM_READY wins and ERR stays 0.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - CNT clears on entry to BUSY and increments each BUSY cycle without MEM_READY.
  - When CNT reaches TIMEOUT: ACK(GNT) = 1, ERR = 1 and RDATA = 0 in that cycle, then IDLE.
  - This gives at most TIMEOUT+1 BUSY cycles.
- Undefined:
  - No counter is built and ERR is tied to 0.
  - BUSY waits indefinitely for MEM_READY.

## Structure
- Shared CPU package holds:
  - the state encodings ST_IDLE = 1'b0 and ST_BUSY = 1'b1;
  - the port index constants PORT_IF = 0 and PORT_MEM = 1;
  - the default timeout constant.
- Address and write-data steering uses two instances of the existing MUX2T1X32 sub-module with select = GNT. MEM_WE is selected inline.

## Test plan
- Single read: REQ0 = 1, ADDR0 = 32'h0000_0040, MEM_READY high with MEM_RDATA = 32'hDEAD_BEEF in the first BUSY cycle -> MEM_ADDR = 32'h40 and ACK0 = 1 with RDATA = 32'hDEADBEEF one cycle after REQ0 rises.
- Tie after reset: REQ0 = REQ1 = 1 continuously, MEM_READY always 1 -> ACK0, ACK1, ACK0, ACK1 on successive BUSY cycles, with an IDLE cycle between each.
- Write steering: REQ1 = 1, WE1 = 1, WDATA1 = 32'h1234_5678, memory delays 3 cycles -> MEM_WE = 1 and MEM_WDATA = 32'h12345678 held for 4 BUSY cycles, then ACK1 = 1.
- Reset mid-operation: RST pulsed in the second BUSY cycle, MEM_READY high one cycle later -> MEM_REQ = 0 after reset and no ACK or ERR ever.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT = 4): REQ0 = 1, MEM_READY held 0 -> ACK0 = ERR = 1 and RDATA = 0 on the fifth BUSY cycle, then IDLE.
- Timeout tie (ARB_TIMEOUT_EN): MEM_READY rises in the expiry cycle -> ACK0 = 1, ERR = 0, RDATA = MEM_RDATA.
